// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the 2-way write-back data cache.
// Controller states, per-way tag entry, address-split width functions.
package dcache_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MISS,
      S_WRITEBACK,
      S_REFILL,
      S_REFILLOK
   } state_e;

   typedef struct packed {
      logic        valid;
      logic        dirty;
      logic [31:0] tag;
   } way_meta_t;

   function automatic int off_w(input int line_bits);
      return $clog2(line_bits / 8);
   endfunction

   function automatic int idx_w(input int num_sets);
      return $clog2(num_sets);
   endfunction

   function automatic int wsel_w(input int line_bits);
      return $clog2(line_bits / 32);
   endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: valid/dirty/tag entries plus line storage, one index port.
// Entries clear on reset; line storage is not reset.
module dcache_way
   import dcache_pkg::*;
#(
   parameter  int NUM_SETS  = 16,
   parameter  int LINE_BITS = 256,
   localparam int IW        = idx_w(NUM_SETS)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IW-1:0]        idx_i,
   input  logic                 we_i,
   input  way_meta_t            wmeta_i,
   input  logic [LINE_BITS-1:0] wline_i,
   output way_meta_t            meta_o,
   output logic [LINE_BITS-1:0] line_o
);

   way_meta_t            meta_q [NUM_SETS];
   logic [LINE_BITS-1:0] line_q [NUM_SETS];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < NUM_SETS; i++) meta_q[i] <= '0;
      end else if (we_i) begin
         meta_q[idx_i] <= wmeta_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (we_i) line_q[idx_i] <= wline_i;
   end

   assign meta_o = meta_q[idx_i];
   assign line_o = line_q[idx_i];

endmodule

// File: rtl/dcache_2way_top.sv
// 2-way set-associative write-back/write-allocate data cache with LRU.
// Define DCACHE_STATS_EN to add saturating hit/miss counter outputs.
module dcache_2way_top
   import dcache_pkg::*;
#(
   parameter int NUM_SETS  = 16,
   parameter int LINE_BITS = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i,
   output logic [LINE_BITS-1:0] mem_data_o,
   output logic [31:0]          mem_addr_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   input  logic [31:0]          p1_data_i,
   input  logic [31:0]          p1_addr_i,
   input  logic                 p1_MemRead_i,
   input  logic                 p1_MemWrite_i,
   output logic [31:0]          p1_data_o,
`ifdef DCACHE_STATS_EN
   output logic                 p1_stall_o,
   output logic [31:0]          stat_hit_o,
   output logic [31:0]          stat_miss_o
`else
   output logic                 p1_stall_o
`endif
);

   localparam int OW = off_w(LINE_BITS);
   localparam int IW = idx_w(NUM_SETS);
   localparam int WS = wsel_w(LINE_BITS);
   localparam int SH = OW + IW;

   state_e               state_q;
   logic                 en_q, wr_q, victim_q;
   logic [31:0]          addr_q;
   logic [LINE_BITS-1:0] refill_q;
   logic [NUM_SETS-1:0]  lru_q;

   way_meta_t            meta  [2];
   way_meta_t            wmeta [2];
   logic [LINE_BITS-1:0] line  [2];
   logic [LINE_BITS-1:0] wline [2];
   logic [1:0]           we, match;
   logic                 req, hit, hw, victim, unused_addr;
   logic [IW-1:0]        idx;
   logic [31:0]          req_tag, vaddr;
   logic [WS+4:0]        bsel;

   assign unused_addr = ^p1_addr_i[1:0];
   assign req     = p1_MemRead_i | p1_MemWrite_i;
   assign req_tag = p1_addr_i >> SH;
   assign idx     = (state_q == S_IDLE) ? p1_addr_i[OW +: IW] : addr_q[OW +: IW];
   assign bsel    = {p1_addr_i[2 +: WS], 5'd0};

   always_comb begin
      for (int w = 0; w < 2; w++)
         match[w] = meta[w].valid && (meta[w].tag == req_tag);
   end

   // a set holding the same tag twice is treated as a miss
   assign hit    = (state_q == S_IDLE) && (match[0] ^ match[1]);
   assign hw     = match[1];
   assign victim = !meta[0].valid ? 1'b0 :
                   !meta[1].valid ? 1'b1 : lru_q[idx];

   assign p1_stall_o   = req & ~hit;
   assign p1_data_o    = line[hw][bsel +: 32];
   assign vaddr        = {meta[victim_q].tag[31-SH:0], addr_q[SH-1:0]};
   assign mem_addr_o   = (state_q == S_WRITEBACK) ? vaddr : addr_q;
   assign mem_data_o   = line[victim_q];
   assign mem_enable_o = en_q;
   assign mem_write_o  = wr_q;

   always_comb begin
      for (int w = 0; w < 2; w++) begin
         we[w]    = 1'b0;
         wmeta[w] = meta[w];
         wline[w] = line[w];
         if (state_q == S_REFILLOK && victim_q == 1'(w)) begin
            we[w]          = 1'b1;
            wmeta[w].valid = 1'b1;
            wmeta[w].dirty = 1'b0;
            wmeta[w].tag   = addr_q >> SH;
            wline[w]       = refill_q;
         end else if (hit && p1_MemWrite_i && hw == 1'(w)) begin
            we[w]                 = 1'b1;
            wmeta[w].dirty        = 1'b1;
            wline[w][bsel +: 32]  = p1_data_i;
         end
      end
   end

   dcache_way #(.NUM_SETS(NUM_SETS), .LINE_BITS(LINE_BITS)) u_way0 (
      .clk_i(clk_i), .rst_i(rst_i), .idx_i(idx), .we_i(we[0]),
      .wmeta_i(wmeta[0]), .wline_i(wline[0]),
      .meta_o(meta[0]), .line_o(line[0])
   );

   dcache_way #(.NUM_SETS(NUM_SETS), .LINE_BITS(LINE_BITS)) u_way1 (
      .clk_i(clk_i), .rst_i(rst_i), .idx_i(idx), .we_i(we[1]),
      .wmeta_i(wmeta[1]), .wline_i(wline[1]),
      .meta_o(meta[1]), .line_o(line[1])
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         en_q     <= 1'b0;
         wr_q     <= 1'b0;
         victim_q <= 1'b0;
         addr_q   <= '0;
         refill_q <= '0;
         lru_q    <= '0;
      end else begin
         if (req && hit) lru_q[idx] <= ~hw;
         unique case (state_q)
            S_IDLE: if (req && !hit) begin
               state_q <= S_MISS;
               addr_q  <= {p1_addr_i[31:OW], {OW{1'b0}}};
            end
            S_MISS: begin
               victim_q <= victim;
               en_q     <= 1'b1;
               if (meta[victim].valid && meta[victim].dirty) begin
                  state_q <= S_WRITEBACK;
                  wr_q    <= 1'b1;
               end else begin
                  state_q <= S_REFILL;
                  wr_q    <= 1'b0;
               end
            end
            S_WRITEBACK: if (mem_ack_i) begin
               state_q <= S_REFILL;
               wr_q    <= 1'b0;
            end
            S_REFILL: if (mem_ack_i) begin
               state_q  <= S_REFILLOK;
               en_q     <= 1'b0;
               refill_q <= mem_data_i;
            end
            S_REFILLOK: begin
               state_q    <= S_IDLE;
               lru_q[idx] <= ~victim_q;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] stat_hit_q, stat_miss_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stat_hit_q  <= '0;
         stat_miss_q <= '0;
      end else begin
         if (req && hit && stat_hit_q != '1)
            stat_hit_q <= stat_hit_q + 32'd1;
         if (state_q == S_IDLE && req && !hit && stat_miss_q != '1)
            stat_miss_q <= stat_miss_q + 32'd1;
      end
   end

   assign stat_hit_o  = stat_hit_q;
   assign stat_miss_o = stat_miss_q;
`endif

endmodule

// File: tb/tb_dcache_2way_top.sv
// Directed bench for dcache_2way_top with a fixed-latency line memory.
// Memory lines default to a per-address pattern unless written back.
module tb_dcache_2way_top;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [255:0] mem_data_i = '0;
   logic         mem_ack_i = 1'b0;
   logic [255:0] mem_data_o;
   logic [31:0]  mem_addr_o;
   logic         mem_enable_o, mem_write_o;
   logic [31:0]  p1_data_i, p1_addr_i, p1_data_o;
   logic         p1_MemRead_i, p1_MemWrite_i, p1_stall_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dcache_2way_top #(.NUM_SETS(16), .LINE_BITS(256)) dut (
      .clk_i(clk), .rst_i(rst_n),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
      .p1_data_i(p1_data_i), .p1_addr_i(p1_addr_i),
      .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
      .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o)
   );

   function automatic logic [255:0] pat(input logic [31:0] a);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'hC0DE_0000 | (a + 32'(w * 4));
      return l;
   endfunction

   // Line memory: ack three cycles into each enabled transfer.
   logic [255:0] wb_mem [logic [31:0]];
   logic [31:0]  wb_addr = '0, rf_addr = '0;
   logic [255:0] wb_line = '0;
   int           wb_cnt = 0, mcnt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_ack_i <= 1'b0;
         mcnt = 0;
      end else begin
         mem_ack_i <= 1'b0;
         if (mem_enable_o && !mem_ack_i) begin
            if (mcnt == 2) begin
               mcnt = 0;
               mem_ack_i <= 1'b1;
               if (mem_write_o) begin
                  wb_mem[mem_addr_o] = mem_data_o;
                  wb_addr = mem_addr_o;
                  wb_line = mem_data_o;
                  wb_cnt++;
               end else begin
                  rf_addr = mem_addr_o;
                  mem_data_i <= wb_mem.exists(mem_addr_o) ?
                                wb_mem[mem_addr_o] : pat(mem_addr_o);
               end
            end else begin
               mcnt++;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns cycles stalled and the load data.
   task automatic access(input bit wr, input logic [31:0] a,
                         input logic [31:0] d, output int lat,
                         output logic [31:0] rd);
      p1_addr_i     = a;
      p1_data_i     = d;
      p1_MemRead_i  = !wr;
      p1_MemWrite_i = wr;
      #1;
      lat = 0;
      while (p1_stall_o && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      rd = p1_data_o;
      @(negedge clk);
      p1_MemRead_i  = 1'b0;
      p1_MemWrite_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   int           lat, k;
   logic [31:0]  rd;
   logic [255:0] exp_line;

   initial begin
      rst_n = 1'b0;
      p1_data_i = '0;
      p1_addr_i = 32'h400;
      p1_MemRead_i = 1'b1;
      p1_MemWrite_i = 1'b0;
      @(negedge clk);
      chk("rst_enable", mem_enable_o, 1'b0);
      chk("rst_write", mem_write_o, 1'b0);
      chk("rst_stall_req", p1_stall_o, 1'b1);
      p1_MemRead_i = 1'b0;
      #1;
      chk("rst_stall_idle", p1_stall_o, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      access(0, 32'h400, 0, lat, rd);
      chk("A_ld400_lat", 32'(lat), 32'd7);
      chk("A_ld400_data", rd, 32'hC0DE_0400);
      chk("A_rf_addr", rf_addr, 32'h400);
      access(1, 32'h404, 32'hDEAD_BEEF, lat, rd);
      chk("A_st404_lat", 32'(lat), 32'd0);
      access(0, 32'h404, 0, lat, rd);
      chk("A_ld404_lat", 32'(lat), 32'd0);
      chk("A_ld404_data", rd, 32'hDEAD_BEEF);
      access(0, 32'h000, 0, lat, rd);
      chk("A_ld000_lat", 32'(lat), 32'd7);
      access(0, 32'h800, 0, lat, rd);
      chk("A_ld800_lat", 32'(lat), 32'd11);
      chk("A_ld800_data", rd, 32'hC0DE_0800);
      chk("A_wb_addr", wb_addr, 32'h400);
      exp_line = pat(32'h400);
      exp_line[63:32] = 32'hDEAD_BEEF;
      chk("A_wb_line", wb_line, exp_line);
      chk("A_rf_addr2", rf_addr, 32'h800);

      do_reset();
      access(0, 32'h000, 0, lat, rd);
      chk("B_ld000_lat", 32'(lat), 32'd7);
      chk("B_ld000_data", rd, 32'hC0DE_0000);
      access(0, 32'h200, 0, lat, rd);
      chk("B_ld200_lat", 32'(lat), 32'd7);
      chk("B_ld200_data", rd, 32'hC0DE_0200);
      access(0, 32'h000, 0, lat, rd);
      chk("B_ld000_hit", 32'(lat), 32'd0);
      access(0, 32'h400, 0, lat, rd);
      chk("B_ld400_lat", 32'(lat), 32'd7);
      chk("B_ld400_data", rd, 32'hC0DE_0400);
      access(0, 32'h000, 0, lat, rd);
      chk("B_ld000_kept", 32'(lat), 32'd0);
      access(0, 32'h200, 0, lat, rd);
      chk("B_ld200_evicted", 32'(lat), 32'd7);

      access(1, 32'h204, 32'h1234_5678, lat, rd);
      chk("C_st204_lat", 32'(lat), 32'd0);
      access(0, 32'h000, 0, lat, rd);
      chk("C_ld000_hit", 32'(lat), 32'd0);
      access(0, 32'h600, 0, lat, rd);
      chk("C_ld600_lat", 32'(lat), 32'd11);
      chk("C_ld600_data", rd, 32'hC0DE_0600);
      chk("C_wb_addr", wb_addr, 32'h200);
      exp_line = pat(32'h200);
      exp_line[63:32] = 32'h1234_5678;
      chk("C_wb_line", wb_line, exp_line);
      chk("C_rf_addr", rf_addr, 32'h600);
      access(0, 32'h204, 0, lat, rd);
      chk("C_ld204_lat", 32'(lat), 32'd7);
      chk("C_ld204_data", rd, 32'h1234_5678);
      chk("C_wb_count", 32'(wb_cnt), 32'd2);

      p1_addr_i = 32'h800;
      p1_MemRead_i = 1'b1;
      k = 0;
      while (!(mem_enable_o && !mem_write_o) && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("D_reach_refill", 1'(k < 20), 1'b1);
      rst_n = 1'b0;
      #1;
      chk("D_rst_enable", mem_enable_o, 1'b0);
      chk("D_rst_write", mem_write_o, 1'b0);
      chk("D_rst_stall", p1_stall_o, 1'b1);
      @(negedge clk);
      p1_MemRead_i = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      access(0, 32'h800, 0, lat, rd);
      chk("D_ld800_lat", 32'(lat), 32'd7);
      chk("D_ld800_data", rd, 32'hC0DE_0800);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
